multicycle_controller: RTL
==========================

# multicycle_controller

Multi-cycle RV32I control unit. It replaces the single-cycle opcode decoder with a state machine that sequences each instruction through fetch, decode, execute, memory and write-back. It handshakes with instruction and data memories that may stall, and it adds branch/jump control, a memory-timeout error and a retired-instruction counter. It sits between the instruction register and the datapath muxes, register file, ALU control and memories.

## Interface
Parameters:
- TIMEOUT, 16: maximum cycles a memory request may wait for ready; 0 disables the timeout.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  7  instruction opcode from the instruction register; valid from DECODE onward.
- funct3  in  3  instruction funct3; valid from DECODE onward.
- branch_taken  in  1  comparison result from the ALU; sampled in EXEC.
- imem_req  out  1  instruction fetch request.
- imem_ready  in  1  instruction memory accepts/returns data this cycle.
- dmem_req  out  1  data memory request.
- dmem_ready  in  1  data memory completes this cycle.
- ir_write  out  1  load the instruction register.
- pc_write  out  1  update the PC.
- pc_src  out  2  next-PC select: 00 = PC+4, 01 = branch/JAL target, 10 = JALR target.
- alu_src  out  1  0 = rs2, 1 = immediate.
- mem_to_reg  out  2  write-back source: 00 = ALU, 01 = memory, 10 = PC+4.
- reg_write  out  1  register file write enable.
- mem_read  out  3  load code: 011 = LB, 001 = LH, 000 = LW, 100 = LBU, 010 = LHU, 101 = none.
- mem_write  out  2  store code: 10 = SB, 01 = SH, 00 = SW, 11 = none.
- alu_op  out  2  00 = add, 01 = branch compare, 10 = funct decode.
- state  out  3  current state encoding, for debug.
- err  out  1  sticky error flag.
- retired  out  CNT_W  count of completed instructions.

## Operation
- States and encodings: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, ERR = 7.
- FETCH:
  - imem_req = 1 until imem_ready = 1.
  - In the ready cycle, ir_write = 1, then go to DECODE.
- DECODE:
  - Latch opcode and funct3 internally.
  - Recognised opcodes are R (0110011), I-ALU (0010011), LOAD (0000011), STORE (0100011), LUI (0110111) and AUIPC (0010111). BRANCH, JAL and JALR are recognised only as described in Configuration.
  - LOAD funct3 must be one of 000, 001, 010, 100, 101. STORE funct3 must be one of 000, 001, 010.
  - Anything else is illegal: go to ERR.
- EXEC:
  - alu_src = 1 for all opcodes except R and BRANCH.
  - alu_op = 10 for R, and for I-ALU with funct3 010 or 001. alu_op = 01 for BRANCH. Otherwise alu_op = 00.
  - Next state: LOAD and STORE go to MEM. BRANCH goes to FETCH. All others go to WB.
- MEM:
  - dmem_req = 1, with mem_read or mem_write driven from the latched funct3, held until dmem_ready = 1.
  - On ready, LOAD goes to WB. STORE retires and goes to FETCH.
- WB (one cycle):
  - reg_write = 1.
  - mem_to_reg = 01 for LOAD, 10 for JAL/JALR, 00 otherwise.
  - pc_write = 1, then go to FETCH.
- PC update: pc_write = 1 on the retiring cycle of every instruction (WB, or the last MEM/EXEC cycle). pc_src follows branch_taken and the jump type.
- retired increments by 1 on each retiring cycle and wraps modulo 2^CNT_W.
- ERR is absorbing:
  - err = 1.
  - All requests and enables are 0; mem_read = 101, mem_write = 11.
  - Only reset exits ERR.
- Timeout: a wait counter clears on entering FETCH or MEM and increments on each cycle with req = 1 and ready = 0. If TIMEOUT ≠ 0 and the counter reaches TIMEOUT with ready still 0, go to ERR on that edge.
- Outside the states named above, every control output sits at its inactive value: 0, with mem_read = 101 and mem_write = 11.

## Timing
- Reset values (held while reset = 1):
  - state = FETCH; err = 0; retired = 0.
  - All control outputs inactive, including imem_req = 0; mem_read = 101, mem_write = 11.
- imem_req rises in the first cycle after reset deasserts.
- Control outputs are decoded from registered state and latched fields only, so they are glitch-free with respect to opcode changes.
- Handshake:
  - A request and its controls stay stable from assertion until the cycle where ready = 1.
  - The transfer completes on that rising edge.
  - ready while req = 0 is ignored.
- Zero-wait latencies: R/I/LUI/AUIPC/JAL/JALR take 4 cycles; LOAD 5; STORE 4; BRANCH 3. Each memory wait cycle adds 1.
- Reset asserted mid-instruction: the instruction is abandoned at that edge, with no reg_write, pc_write or retire, and the FSM returns to FETCH.
- Ready arriving in the same cycle the counter reaches TIMEOUT counts as success; ready wins.

## Configuration
- MC_CTRL_BRANCH_EN defined:
  - BRANCH (1100011), JAL (1101111) and JALR (1100111) are legal.
  - pc_src is 01 for a taken branch or JAL, and 10 for JALR.
  - JAL and JALR write PC+4 in WB.
- Not defined:
  - Those three opcodes go to ERR.
  - pc_src is constant 00.
  - mem_to_reg never takes the value 10.

## Test plan
- ADD (0110011), zero-wait memories: state sequence 0,1,2,4,0; reg_write and pc_write high exactly in WB; retired goes 0 to 1.
- LH (funct3 001) with dmem_ready delayed 3 cycles: mem_read = 001 and dmem_req held for 4 cycles; WB mem_to_reg = 01; total 8 cycles.
- SB (funct3 000): mem_write = 10 in MEM; no reg_write; retired increments on the dmem_ready cycle.
- TIMEOUT = 4, imem_ready held at 0: ERR after 4 wait cycles; err = 1 and stays; mem_read = 101; only reset clears it.
- With MC_CTRL_BRANCH_EN, BEQ with branch_taken = 1: pc_src = 01 and pc_write in EXEC; 3 cycles. Without the macro, the same opcode goes to ERR.
- Reset asserted during MEM of LW: next state FETCH, dmem_req = 0, retired unchanged; illegal opcode 1111111 → ERR from DECODE.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Memory handshake bundle between the multicycle controller (master)
// and the instruction/data memories (slave).
interface multicycle_controller_if;
  logic imem_req;
  logic imem_ready;
  logic dmem_req;
  logic dmem_ready;

  modport master (
    output imem_req,
    output dmem_req,
    input  imem_ready,
    input  dmem_ready
  );

  modport slave (
    input  imem_req,
    input  dmem_req,
    output imem_ready,
    output dmem_ready
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with stalling memories,
// memory timeout into a sticky ERR state, and a retired counter. MC_CTRL_BRANCH_EN adds BRANCH/JAL/JALR.
module multicycle_controller #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_controller_if.master mem,
  input  logic [6:0]             opcode,
  input  logic [2:0]             funct3,
  input  logic                   branch_taken,
  output logic                   ir_write,
  output logic                   pc_write,
  output logic [1:0]             pc_src,
  output logic                   alu_src,
  output logic [1:0]             mem_to_reg,
  output logic                   reg_write,
  output logic [2:0]             mem_read,
  output logic [1:0]             mem_write,
  output logic [1:0]             alu_op,
  output logic [2:0]             state,
  output logic                   err,
  output logic [CNT_W-1:0]       retired
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_ERR    = 3'd7;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

`ifdef MC_CTRL_BRANCH_EN
  localparam bit BRANCH_EN = 1'b1;
`else
  localparam bit BRANCH_EN = 1'b0;
`endif

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [2:0]        state_q, state_d;
  logic [6:0]        op_q;
  logic [2:0]        f3_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_expired;
  logic              is_r, is_imm, is_load, is_store, is_branch, is_jal, is_jalr;

  function automatic logic legal(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      OP_R, OP_IMM, OP_LUI, OP_AUIPC: legal = 1'b1;
      OP_LOAD:  legal = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
      OP_STORE: legal = (f3 <= 3'b010);
      OP_BRANCH, OP_JAL, OP_JALR: legal = BRANCH_EN;
      default:  legal = 1'b0;
    endcase
  endfunction

  assign is_r      = (op_q == OP_R);
  assign is_imm    = (op_q == OP_IMM);
  assign is_load   = (op_q == OP_LOAD);
  assign is_store  = (op_q == OP_STORE);
  assign is_branch = (op_q == OP_BRANCH);
  assign is_jal    = (op_q == OP_JAL);
  assign is_jalr   = (op_q == OP_JALR);

  // The wait counter holds the number of stalled cycles already spent, so the
  // TIMEOUT-th stalled cycle is the last one allowed; ready in that cycle still wins.
  assign wait_expired = (TIMEOUT != 0) && (wait_cnt == WAIT_W'(TIMEOUT - 1));

  assign state = state_q;

  // NOTE: every always_comb target gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem.imem_ready) state_d = S_DECODE;
                else if (wait_expired) state_d = S_ERR;
      S_DECODE: state_d = legal(opcode, funct3) ? S_EXEC : S_ERR;
      S_EXEC:   if (is_load || is_store) state_d = S_MEM;
                else if (is_branch) state_d = S_FETCH;
                else state_d = S_WB;
      S_MEM:    if (mem.dmem_ready) state_d = is_load ? S_WB : S_FETCH;
                else if (wait_expired) state_d = S_ERR;
      S_WB:     state_d = S_FETCH;
      S_ERR:    state_d = S_ERR;
      default:  state_d = S_FETCH;
    endcase
  end

  // NOTE: outputs are forced inactive while reset is high, so an instruction caught
  // by reset never writes, retires or issues a request in that cycle.
  always_comb begin
    mem.imem_req = 1'b0;
    mem.dmem_req = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 2'b00;
    alu_src      = 1'b0;
    mem_to_reg   = 2'b00;
    reg_write    = 1'b0;
    mem_read     = 3'b101;
    mem_write    = 2'b11;
    alu_op       = 2'b00;
    err          = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem.imem_req = 1'b1;
          ir_write     = mem.imem_ready;
        end
        S_EXEC: begin
          alu_src = !(is_r || is_branch);
          if (is_r || (is_imm && (f3_q == 3'b010 || f3_q == 3'b001))) alu_op = 2'b10;
          else if (is_branch) alu_op = 2'b01;
          if (is_branch) begin
            pc_write = 1'b1;
            pc_src   = (BRANCH_EN && branch_taken) ? 2'b01 : 2'b00;
          end
        end
        S_MEM: begin
          mem.dmem_req = 1'b1;
          if (is_load) begin
            case (f3_q)
              3'b000:  mem_read = 3'b011;
              3'b001:  mem_read = 3'b001;
              3'b010:  mem_read = 3'b000;
              3'b100:  mem_read = 3'b100;
              3'b101:  mem_read = 3'b010;
              default: mem_read = 3'b101;
            endcase
          end
          if (is_store) begin
            case (f3_q)
              3'b000:  mem_write = 2'b10;
              3'b001:  mem_write = 2'b01;
              3'b010:  mem_write = 2'b00;
              default: mem_write = 2'b11;
            endcase
            pc_write = mem.dmem_ready;
          end
        end
        S_WB: begin
          reg_write = 1'b1;
          pc_write  = 1'b1;
          if (is_load) mem_to_reg = 2'b01;
          else if (BRANCH_EN && (is_jal || is_jalr)) mem_to_reg = 2'b10;
          if (BRANCH_EN && is_jal) pc_src = 2'b01;
          else if (BRANCH_EN && is_jalr) pc_src = 2'b10;
        end
        S_ERR:   err = 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      op_q     <= '0;
      f3_q     <= '0;
      wait_cnt <= '0;
      retired  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        op_q <= opcode;
        f3_q <= funct3;
      end
      if (state_d != state_q) wait_cnt <= '0;
      else if ((mem.imem_req && !mem.imem_ready) || (mem.dmem_req && !mem.dmem_ready))
        wait_cnt <= wait_cnt + WAIT_W'(1);
      // pc_write is high exactly on the retiring cycle of each instruction.
      if (pc_write) retired <= retired + CNT_W'(1);
    end
  end

endmodule
